primogen_seek: RTL and testbench

Parametrised successor to the sequential prime generator. It searches for the next prime by trial division, using the existing divmod block for each modulo. It adds a loadable start value, so a search can begin at an arbitrary `from`. It also exports a saturating count of primes produced and replaces overflow-prone squared-divisor arithmetic with a double-width comparison. It sits as a slave behind a go/ready handshake, e.g. in the test harness or a key-generation front end.

---
 rtl/primogen_seek.sv | 227 ++++++++++++++++++++++
 tb/tb_primogen_seek.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/primogen_seek.sv
// Next-prime search by trial division, with a loadable start value and a saturating prime counter.
// Define PRIMOGEN_ODD_STEP_EN to skip even candidates and even divisors above 2 (results unchanged).
module primogen_divmod #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         go,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         ready,
   output logic         error,
   output logic [W-1:0] mod
);
   localparam int CW = $clog2(W) + 1;

   logic          busy;
   logic [W-1:0]  rem;
   logic [W-1:0]  q;
   logic [CW-1:0] cnt;
   logic [W:0]    rem_sh;
   logic          ge;
   logic [W-1:0]  sub;

   // The true difference always fits in W bits when ge is set, so the wrapped subtract is exact.
   always_comb begin
      rem_sh = {rem, q[W-1]};
      ge     = rem_sh >= {1'b0, b};
      sub    = rem_sh[W-1:0] - b;
   end

   assign mod = rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         ready <= 1'b1;
         error <= 1'b0;
         rem   <= '0;
         q     <= '0;
         cnt   <= '0;
      end else if (!busy) begin
         if (go) begin
            if (b == '0) begin
               error <= 1'b1;
               ready <= 1'b1;
            end else begin
               busy  <= 1'b1;
               ready <= 1'b0;
               error <= 1'b0;
               q     <= a;
               rem   <= '0;
               cnt   <= CW'(W);
            end
         end
      end else begin
         rem <= ge ? sub : rem_sh[W-1:0];
         q   <= {q[W-2:0], 1'b0};
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            ready <= 1'b1;
         end
      end
   end
endmodule

module primogen_seek #(
   parameter  int WIDTH_LOG = 4,
   parameter  int CNT_WIDTH = 8,
   localparam int W         = 1 << WIDTH_LOG
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go,
   input  logic                 load,
   input  logic [W-1:0]         from,
   output logic                 ready,
   output logic                 error,
   output logic [W-1:0]         res,
   output logic [CNT_WIDTH-1:0] count
);
   // state    | meaning
   // IDLE     | waiting for go, res valid
   // ERROR    | last search overflowed or divmod failed; sticky until a load
   // CHECK    | candidate p proven prime once div^2 exceeds it, else try div
   // MOD_DLY  | divmod registering its operands
   // MOD_WAIT | waiting for p mod div
   typedef enum logic [2:0] {IDLE, ERROR, CHECK, MOD_DLY, MOD_WAIT} state_t;

   state_t         state;
   logic [W-1:0]   p;
   logic [W-1:0]   div;
   logic [2*W-1:0] dsq;
   logic           dm_go;
   logic           dm_ready;
   logic           dm_error;
   logic [W-1:0]   dm_mod;
   logic [W:0]     p_step;
   logic [W-1:0]   div_nxt;
   logic [2*W-1:0] dsq_nxt;
   logic [2*W-1:0] div_ext;

   function automatic logic [W-1:0] first_cand(input logic [W-1:0] v);
      logic [W-1:0] c;
      c = (v < W'(2)) ? W'(2) : v;
`ifdef PRIMOGEN_ODD_STEP_EN
      if (!c[0] && c != W'(2)) c = c + 1'b1;
`endif
      return c;
   endfunction

   // p_step[W] flags that the next candidate would not fit in W bits.
   always_comb begin
      div_ext = {{W{1'b0}}, div};
`ifdef PRIMOGEN_ODD_STEP_EN
      p_step = {1'b0, p} + ((p == W'(2)) ? (W+1)'(1) : (W+1)'(2));
      if (div == W'(2)) begin
         div_nxt = W'(3);
         dsq_nxt = dsq + (2*W)'(5);
      end else begin
         div_nxt = div + W'(2);
         dsq_nxt = dsq + (div_ext << 2) + (2*W)'(4);
      end
`else
      p_step  = {1'b0, p} + (W+1)'(1);
      div_nxt = div + W'(1);
      dsq_nxt = dsq + (div_ext << 1) + (2*W)'(1);
`endif
   end

   primogen_divmod #(.W(W)) u_divmod (
      .clk   (clk),
      .rst   (rst),
      .go    (dm_go),
      .a     (p),
      .b     (div),
      .ready (dm_ready),
      .error (dm_error),
      .mod   (dm_mod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ready <= 1'b1;
         error <= 1'b0;
         res   <= W'(1);
         count <= '0;
         dm_go <= 1'b0;
      end else begin
         case (state)
            IDLE, ERROR: begin
               dm_go <= 1'b0;
               if (go && load) begin
                  p     <= first_cand(from);
                  div   <= W'(2);
                  dsq   <= (2*W)'(4);
                  state <= CHECK;
                  ready <= 1'b0;
                  error <= 1'b0;
               end else if (go && state == IDLE) begin
                  if (res == '1) begin
                     state <= ERROR;
                     error <= 1'b1;
                  end else begin
                     p     <= first_cand(res + 1'b1);
                     div   <= W'(2);
                     dsq   <= (2*W)'(4);
                     state <= CHECK;
                     ready <= 1'b0;
                  end
               end
            end
            CHECK: begin
               if (dsq > {{W{1'b0}}, p}) begin
                  res   <= p;
                  count <= (count == '1) ? count : count + 1'b1;
                  state <= IDLE;
                  ready <= 1'b1;
                  error <= 1'b0;
               end else begin
                  dm_go <= 1'b1;
                  state <= MOD_DLY;
               end
            end
            MOD_DLY: begin
               dm_go <= 1'b0;
               state <= MOD_WAIT;
            end
            MOD_WAIT: begin
               if (dm_error) begin
                  state <= ERROR;
                  ready <= 1'b1;
                  error <= 1'b1;
               end else if (dm_ready) begin
                  if (dm_mod == '0) begin
                     if (p_step[W]) begin
                        state <= ERROR;
                        ready <= 1'b1;
                        error <= 1'b1;
                     end else begin
                        p     <= p_step[W-1:0];
                        div   <= W'(2);
                        dsq   <= (2*W)'(4);
                        state <= CHECK;
                     end
                  end else begin
                     div   <= div_nxt;
                     dsq   <= dsq_nxt;
                     state <= CHECK;
                  end
               end
            end
            default: begin
               state <= state_t'('x);
               ready <= 1'bx;
               error <= 1'bx;
               dm_go <= 1'bx;
               p     <= 'x;
               div   <= 'x;
               dsq   <= 'x;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_primogen_seek.sv
// Bench for primogen_seek: directed and random searches against an arithmetic next-prime model.
module tb_primogen_seek;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        go = 1'b0;
   logic        load = 1'b0;
   logic [15:0] from = '0;
   logic        ready, error, ready2, error2;
   logic [15:0] res, res2;
   logic [7:0]  count;
   logic [1:0]  count2;

   int errors = 0;
   int checks = 0;
   int m_res, m_cnt;
   bit m_err;

   always #5 clk = ~clk;

   primogen_seek #(.WIDTH_LOG(4), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .go(go), .load(load), .from(from),
      .ready(ready), .error(error), .res(res), .count(count)
   );

   primogen_seek #(.WIDTH_LOG(4), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .go(go), .load(load), .from(from),
      .ready(ready2), .error(error2), .res(res2), .count(count2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_prime(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++)
         if (n % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_search(input int start);
      int n = start;
      while (n <= 65535 && !is_prime(n)) n++;
      if (n > 65535) m_err = 1'b1;
      else begin
         m_res = n;
         m_err = 1'b0;
         m_cnt++;
      end
   endtask

   task automatic model_go(input bit ld, input int f);
      if (ld) model_search(f < 2 ? 2 : f);
      else if (!m_err) begin
         if (m_res == 65535) m_err = 1'b1;
         else model_search(m_res + 1 < 2 ? 2 : m_res + 1);
      end
   endtask

   task automatic model_reset();
      m_res = 1;
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_res"},    32'(res),    32'(m_res));
      chk({tag, "_error"},  32'(error),  32'(m_err));
      chk({tag, "_count"},  32'(count),  32'(m_cnt > 255 ? 255 : m_cnt));
      chk({tag, "_count2"}, 32'(count2), 32'(m_cnt > 3 ? 3 : m_cnt));
      chk({tag, "_res2"},   32'(res2),   32'(m_res));
   endtask

   task automatic wait_ready(input string tag);
      int cyc = 0;
      while (!ready && cyc < 30000) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_ready"}, 32'(ready), 32'd1);
   endtask

   task automatic do_op(input bit ld, input int f, input string tag);
      @(negedge clk);
      go = 1'b1;
      load = ld;
      from = 16'(f);
      @(negedge clk);
      go = 1'b0;
      wait_ready(tag);
      model_go(ld, f);
      check_outputs(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_dm_go", 32'(dut.dm_go), 32'd0);
      check_outputs("rst");

      for (int i = 0; i < 5; i++) do_op(1'b0, 0, $sformatf("seq%0d", i));

      do_op(1'b1, 24, "from24");
      do_op(1'b1, 29, "from29");
      do_op(1'b1, 0, "from0");

      do_op(1'b1, 65520, "top");
      do_op(1'b0, 0, "ovf");
      chk("ovf_ready", 32'(ready), 32'd1);
      do_op(1'b0, 0, "ovf_sticky");
      do_op(1'b1, 100, "recover");

      for (int i = 0; i < 6; i++) begin
         bit ld = ($urandom_range(0, 3) != 0);
         int f = $urandom_range(0, 4095);
         do_op(ld, f, $sformatf("rnd%0d", i));
      end

      // A go while busy must be dropped without disturbing the running search.
      @(negedge clk);
      go = 1'b1; load = 1'b1; from = 16'd997;
      @(negedge clk);
      go = 1'b0;
      repeat (6) @(negedge clk);
      chk("busy_ready", 32'(ready), 32'd0);
      go = 1'b1; load = 1'b1; from = 16'd0;
      @(negedge clk);
      go = 1'b0;
      wait_ready("busy");
      model_go(1'b1, 997);
      check_outputs("busy");
      repeat (40) @(negedge clk);
      chk("busy_idle", 32'(ready), 32'd1);
      check_outputs("busy_after");

      // Reset landing in the middle of a divmod wait.
      @(negedge clk);
      go = 1'b1; load = 1'b1; from = 16'd1000;
      @(negedge clk);
      go = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst_busy", 32'(ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_dm_go", 32'(dut.dm_go), 32'd0);
      check_outputs("midrst");

      do_op(1'b0, 0, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
